// File: rtl/rf_writeback_unit_pkg.sv
// Shared definitions for the register-file writeback unit.
// Holds the default data/index widths and the encoding of the writeback
// source chosen by the arbiter each cycle.
package rf_writeback_unit_pkg;

  localparam int DEFAULT_REG_WIDTH      = 32;
  localparam int DEFAULT_REG_ADDR_WIDTH = 5;

  // Writeback source selected in a cycle (priority ALU > HOLD > RSP).
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_HOLD = 2'd2,
    WB_RSP  = 2'd3
  } wb_src_e;

  // True when the selected source retires the load at the tag-queue head.
  function automatic logic is_load_src(input wb_src_e src);
    return (src == WB_HOLD) || (src == WB_RSP);
  endfunction

endpackage

// File: rtl/wb_tag_fifo.sv
// Destination-tag queue for outstanding loads.
// Circular FIFO of DEPTH entries with one valid bit per slot, so the
// hazard logic can compare against every outstanding tag.
// Ports:
//   clk, srst          clock and synchronous active-high reset
//   push, push_tag     enqueue a tag (ignored when full)
//   pop                dequeue the head (ignored when empty)
//   full, empty        registered occupancy flags
//   head_tag           tag at the queue head
//   entry_valid        per-slot valid bits
//   entry_tag          per-slot tags, slot i at [i*TAG_WIDTH +: TAG_WIDTH]
module wb_tag_fifo #(
  parameter int DEPTH     = 2,
  parameter int TAG_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  logic [TAG_WIDTH-1:0]       push_tag,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [TAG_WIDTH-1:0]       head_tag,
  output logic [DEPTH-1:0]           entry_valid,
  output logic [DEPTH*TAG_WIDTH-1:0] entry_tag
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [TAG_WIDTH-1:0] tag_reg [DEPTH];
  logic [DEPTH-1:0]     valid_reg;
  logic [DEPTH-1:0]     valid_set;
  logic [DEPTH-1:0]     valid_clr;
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic                 push_ok;
  logic                 pop_ok;

  assign full     = &valid_reg;
  assign empty    = ~|valid_reg;
  // Full/empty come from registered state only, so a push while full is
  // rejected even if a pop happens in the same cycle.
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head_tag = tag_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign valid_set[gi] = push_ok && (wr_ptr_reg == AW'(gi));
      assign valid_clr[gi] = pop_ok  && (rd_ptr_reg == AW'(gi));
      assign entry_valid[gi] = valid_reg[gi];
      assign entry_tag[gi*TAG_WIDTH +: TAG_WIDTH] = tag_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      valid_reg <= (valid_reg | valid_set) & ~valid_clr;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Tag storage needs no reset: slots are qualified by valid_reg.
  always_ff @(posedge clk) begin
    if (push_ok) tag_reg[wr_ptr_reg] <= push_tag;
  end

endmodule

// File: rtl/rf_writeback_unit.sv
// Register-file writeback unit.
// Merges single-cycle ALU results and in-order load responses onto one
// registered register-file write port, tracks outstanding load
// destinations and reports read/write hazards against pending writes.
// Ports:
//   Clk_i, Rst_i                        clock, synchronous active-high reset
//   Alu_Valid_i/Alu_Rd_i/Alu_Data_i     ALU result (highest priority)
//   Ld_Issue_i/Ld_Rd_i/Ld_Issue_Ready_o load issue, destination tag enqueue
//   Ld_Rsp_Valid_i/Ld_Rsp_Data_i/Ld_Rsp_Ready_o  load data return
//   Ra_Sel_i/Rb_Sel_i/Rq_Sel_i/Hazard_o hazard query
//   Data_We_o/Rd_Sel_o/Data_o           registered register-file write
module rf_writeback_unit
  import rf_writeback_unit_pkg::*;
#(
  parameter int REG_WIDTH      = DEFAULT_REG_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
  parameter int LDQ_DEPTH      = 2
) (
  input  logic                      Clk_i,
  input  logic                      Rst_i,
  input  logic                      Alu_Valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] Alu_Rd_i,
  input  logic [REG_WIDTH-1:0]      Alu_Data_i,
  input  logic                      Ld_Issue_i,
  input  logic [REG_ADDR_WIDTH-1:0] Ld_Rd_i,
  output logic                      Ld_Issue_Ready_o,
  input  logic                      Ld_Rsp_Valid_i,
  input  logic [REG_WIDTH-1:0]      Ld_Rsp_Data_i,
  output logic                      Ld_Rsp_Ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] Ra_Sel_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rb_Sel_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rq_Sel_i,
  output logic                      Hazard_o,
  output logic                      Data_We_o,
  output logic [REG_ADDR_WIDTH-1:0] Rd_Sel_o,
  output logic [REG_WIDTH-1:0]      Data_o
);

  logic                                tag_full;
  logic                                tag_empty;
  logic [REG_ADDR_WIDTH-1:0]           head_tag;
  logic [LDQ_DEPTH-1:0]                entry_valid;
  logic [LDQ_DEPTH*REG_ADDR_WIDTH-1:0] entry_tag;
  logic [REG_ADDR_WIDTH-1:0]           slot_tag [LDQ_DEPTH];

  logic                      hold_valid_reg, hold_valid_next;
  logic [REG_WIDTH-1:0]      hold_data_reg,  hold_data_next;
  logic                      we_reg,         we_next;
  logic [REG_ADDR_WIDTH-1:0] rd_reg,         rd_next;
  logic [REG_WIDTH-1:0]      data_reg,       data_next;

  wb_src_e src;
  logic    push;
  logic    pop;
  logic    rsp_fire;
  logic    hazard;
  logic [REG_ADDR_WIDTH-1:0] query [3];

  assign Ld_Issue_Ready_o = ~tag_full;
  assign Ld_Rsp_Ready_o   = ~hold_valid_reg;
  assign push             = Ld_Issue_i & ~tag_full;
  // A response with no outstanding tag has nothing to pair with: drop it.
  assign rsp_fire         = Ld_Rsp_Valid_i & ~hold_valid_reg & ~tag_empty;
  assign pop              = is_load_src(src);

  wb_tag_fifo #(
    .DEPTH     (LDQ_DEPTH),
    .TAG_WIDTH (REG_ADDR_WIDTH)
  ) u_tag_fifo (
    .clk         (Clk_i),
    .srst        (Rst_i),
    .push        (push),
    .push_tag    (Ld_Rd_i),
    .pop         (pop),
    .full        (tag_full),
    .empty       (tag_empty),
    .head_tag    (head_tag),
    .entry_valid (entry_valid),
    .entry_tag   (entry_tag)
  );

  // Writeback source priority: ALU, then held load, then fresh response.
  always_comb begin
    src = WB_NONE;
    if (Alu_Valid_i)         src = WB_ALU;
    else if (hold_valid_reg) src = WB_HOLD;
    else if (rsp_fire)       src = WB_RSP;
  end

  always_comb begin
    hold_valid_next = hold_valid_reg;
    hold_data_next  = hold_data_reg;
    we_next         = 1'b0;
    rd_next         = rd_reg;
    data_next       = data_reg;
    case (src)
      WB_ALU: begin
        rd_next   = Alu_Rd_i;
        data_next = Alu_Data_i;
      end
      WB_HOLD: begin
        rd_next         = head_tag;
        data_next       = hold_data_reg;
        hold_valid_next = 1'b0;
      end
      WB_RSP: begin
        rd_next   = head_tag;
        data_next = Ld_Rsp_Data_i;
      end
      default: ;
    endcase
    // Register 0 is hard-wired: a result aimed at it still retires but never writes.
    if (src != WB_NONE) we_next = (rd_next != '0);
    // An accepted response that lost to the ALU parks in the hold register.
    if (rsp_fire && (src == WB_ALU)) begin
      hold_valid_next = 1'b1;
      hold_data_next  = Ld_Rsp_Data_i;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
      we_reg         <= 1'b0;
      rd_reg         <= '0;
      data_reg       <= '0;
    end else begin
      hold_valid_reg <= hold_valid_next;
      hold_data_reg  <= hold_data_next;
      we_reg         <= we_next;
      rd_reg         <= rd_next;
      data_reg       <= data_next;
    end
  end

  assign Data_We_o = we_reg;
  assign Rd_Sel_o  = rd_reg;
  assign Data_o    = data_reg;

  // Hazard: a nonzero query matching any outstanding load tag or the write
  // currently on the register-file port.
  assign query[0] = Ra_Sel_i;
  assign query[1] = Rb_Sel_i;
  assign query[2] = Rq_Sel_i;

  genvar gi;
  generate
    for (gi = 0; gi < LDQ_DEPTH; gi++) begin : g_slot_tag
      assign slot_tag[gi] = entry_tag[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    end
  endgenerate

  always_comb begin
    hazard = 1'b0;
    for (int q = 0; q < 3; q++) begin
      if (query[q] != '0) begin
        if (we_reg && (rd_reg == query[q])) hazard = 1'b1;
        for (int e = 0; e < LDQ_DEPTH; e++) begin
          if (entry_valid[e] && (slot_tag[e] == query[q])) hazard = 1'b1;
        end
      end
    end
  end

  assign Hazard_o = hazard;

endmodule

// File: doc/rf_writeback_unit.md
RF_WRITEBACK_UNIT -- requirements
Module: rf_writeback_unit

Interface
REQ-001 Parameter REG_WIDTH, default 32, data width of every result and write bus.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, register index width.
REQ-003 Parameter LDQ_DEPTH, default 2, number of outstanding loads tracked (power of 2, >=2).
REQ-004 Clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 Rst_i  input  1  synchronous, active-high reset.
REQ-006 Alu_Valid_i  input  1  single-cycle ALU result valid this cycle; no backpressure.
REQ-007 Alu_Rd_i  input  REG_ADDR_WIDTH  ALU destination index.
REQ-008 Alu_Data_i  input  REG_WIDTH  ALU result.
REQ-009 Ld_Issue_i  input  1  load issued this cycle; enqueue destination tag.
REQ-010 Ld_Rd_i  input  REG_ADDR_WIDTH  destination index of issued load.
REQ-011 Ld_Issue_Ready_o  output  1  tag queue not full; Ld_Issue_i is ignored when low.
REQ-012 Ld_Rsp_Valid_i  input  1  load data returned; responses arrive in issue order.
REQ-013 Ld_Rsp_Data_i  input  REG_WIDTH  load data.
REQ-014 Ld_Rsp_Ready_o  output  1  load hold register empty; response accepted when Valid and Ready both high.
REQ-015 Ra_Sel_i, Rb_Sel_i, Rq_Sel_i  input  REG_ADDR_WIDTH each  hazard-query indices (two sources, one destination).
REQ-016 Hazard_o  output  1  combinational; any query index has a pending write.
REQ-017 Data_We_o  output  1  write enable to register file.
REQ-018 Rd_Sel_o  output  REG_ADDR_WIDTH  write index to register file.
REQ-019 Data_o  output  REG_WIDTH  write data to register file.

Function
REQ-020 Outputs Data_We_o/Rd_Sel_o/Data_o SHALL be registered; a selected result appears exactly 1 cycle after acceptance.
REQ-021 Arbitration each cycle: ALU result wins; otherwise the load hold register; otherwise the incoming accepted load response; otherwise Data_We_o=0 next cycle.
REQ-022 An accepted load response that loses arbitration SHALL be stored in a 1-entry hold register; Ld_Rsp_Ready_o=0 while the hold register is full.
REQ-023 A load result SHALL pair with the tag at the queue head; the head pops in the cycle the load result is selected for writeback.
REQ-024 Tag queue: circular FIFO of depth LDQ_DEPTH; simultaneous push and pop when full SHALL be rejected (Ready reflects registered state only); push when empty together with pop is impossible by construction.
REQ-025 Load response when tag queue empty SHALL be dropped; no write, no state change.
REQ-026 Destination index 0 SHALL never assert Data_We_o; an rd=0 load still occupies a tag slot to preserve ordering.
REQ-027 Hazard_o=1 when any nonzero query index equals a valid queue tag, or equals Rd_Sel_o while Data_We_o=1.
REQ-028 Index 0 SHALL never raise Hazard_o.
REQ-029 Upstream SHALL hold Alu_Valid_i low when the Rq_Sel_i query hits (WAW); the block does not re-order.
REQ-030 Alu_Rd_i is written as presented; no width extension or data modification occurs.

Reset
REQ-031 On Rst_i: Data_We_o=0, Rd_Sel_o=0, Data_o=0, tag queue empty, hold register empty.
REQ-032 After reset: Ld_Issue_Ready_o=1, Ld_Rsp_Ready_o=1, Hazard_o=0.
REQ-033 Reset mid-operation SHALL discard all outstanding tags and held data; no write is produced for them.

Structure
REQ-034 The shared core package SHALL hold REG_WIDTH/REG_ADDR_WIDTH defaults and the writeback-source encoding (NONE, ALU, HOLD, RSP).
REQ-035 The tag queue SHALL be one sub-module, wb_tag_fifo, with push/pop/full/empty and a per-entry valid/tag view for hazard compare.

Verification
REQ-036 ALU rd=5 data 0xDEADBEEF in cycle N -> Data_We_o=1, Rd_Sel_o=5, Data_o=0xDEADBEEF in cycle N+1.
REQ-037 Issue load rd=7, respond 0x1234 three cycles later -> Hazard_o=1 for Ra_Sel_i=7 until the write cycle, then a write of 7/0x1234, then Hazard_o=0.
REQ-038 Load response and ALU result rd=3 in the same cycle -> ALU written at N+1, load written at N+2, Ld_Rsp_Ready_o=0 during N+1.
REQ-039 Issue 2 loads (depth 2) -> Ld_Issue_Ready_o=0, third issue ignored, responses write rd tags in issue order.
REQ-040 Load rd=0 plus query Ra=0 -> no write, Hazard_o=0, tag popped on response.
REQ-041 Rst_i asserted with 2 tags and hold full -> next cycle queue empty, Data_We_o=0, later stray response dropped.
